// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM states, default feedback mask and Galois LFSR helpers
package lfsr_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;

    // Helpers work on 64-bit containers so any word width below 64 can reuse them
    function automatic logic [63:0] fix_seed(input logic [63:0] s);
        return (s == '0) ? 64'd1 : s;
    endfunction

    function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [63:0] taps);
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Galois LFSR register with seed load (zero seed forced to 1) and step enable
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] TAPS       = DATA_WIDTH'(DEFAULT_TAPS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic [DATA_WIDTH-1:0] state_o
);

    logic [63:0] seeded;
    logic [63:0] stepped;
    logic        unused_hi;

    assign seeded    = fix_seed(64'(seed_i));
    assign stepped   = lfsr_step(64'(state_o), 64'(TAPS));
    assign unused_hi = ^{seeded[63:DATA_WIDTH], stepped[63:DATA_WIDTH]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_o <= '0;
        else if (load_i)
            state_o <= seeded[DATA_WIDTH-1:0];
        else if (en_i)
            state_o <= stepped[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/lfsr_ram_filler.sv
// lfsr_ram_filler: fills RAM[0..FILL_DEPTH-1] with an LFSR sequence from a seed.
// Define LFSR_FILL_READBACK_EN to add readback of the filled words and a mismatch counter.
module lfsr_ram_filler
    import lfsr_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FILL_DEPTH = 1000,
    parameter logic [DATA_WIDTH-1:0] TAPS       = DATA_WIDTH'(DEFAULT_TAPS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  ram_we_o,
    output logic                  ram_rd_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] err_cnt_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FILL_DEPTH - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   lfsr;
    logic [DATA_WIDTH-1:0]   load_seed;
    logic                    load;
    logic                    en;
    logic                    last;

    assign last = addr == LAST;

`ifdef LFSR_FILL_READBACK_EN
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic                  cmp_q;
    logic [ADDR_WIDTH-1:0] err_q;
    // The last write reloads the captured seed so readback regenerates the same sequence
    assign load      = (state == IDLE && start_i) || (state == WRITE && last);
    assign load_seed = (state == IDLE) ? seed_i : seed_q;
    assign en        = state == WRITE || state == READ;
    assign ram_rd_o  = state == READ;
    assign err_cnt_o = err_q;
`else
    logic unused_rd;
    assign load      = state == IDLE && start_i;
    assign load_seed = seed_i;
    assign en        = state == WRITE;
    assign ram_rd_o  = 1'b0;
    assign err_cnt_o = '0;
    assign unused_rd = ^ram_data_i;
`endif

    assign ram_we_o   = state == WRITE;
    assign ram_addr_o = (ram_we_o || ram_rd_o) ? addr : '0;
    assign ram_data_o = ram_we_o ? lfsr : '0;
    assign busy_o     = state != IDLE;
    assign done_o     = state == DONE;

    lfsr_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .TAPS      (TAPS)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .en_i   (en),
        .seed_i (load_seed),
        .state_o(lfsr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            addr  <= '0;
`ifdef LFSR_FILL_READBACK_EN
            seed_q <= '0;
            exp_q  <= '0;
            cmp_q  <= 1'b0;
            err_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    state <= WRITE;
                    addr  <= '0;
`ifdef LFSR_FILL_READBACK_EN
                    seed_q <= seed_i;
                    err_q  <= '0;
`endif
                end
                WRITE: if (last) begin
                    addr <= '0;
`ifdef LFSR_FILL_READBACK_EN
                    state <= READ;
`else
                    state <= DONE;
`endif
                end else begin
                    addr <= addr + 1'b1;
                end
`ifdef LFSR_FILL_READBACK_EN
                READ: if (last) state <= DRAIN;
                      else addr <= addr + 1'b1;
                DRAIN: state <= DONE;
`endif
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef LFSR_FILL_READBACK_EN
            // Read data arrives one cycle late, so the expected word is delayed to match
            cmp_q <= state == READ;
            exp_q <= lfsr;
            if (cmp_q && ram_data_i != exp_q && err_q != '1)
                err_q <= err_q + 1'b1;
`endif
        end
    end

endmodule
